// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the VGA game pipeline.
//
// Divides pclk down to the pixel rate and runs the horizontal/vertical
// counters plus one phase FSM per axis (active, front porch, sync, back porch).
// x, y and video_on come straight from the counter registers. The syncs are
// delayed by SYNC_DELAY pclk cycles so they line up with the renderer's
// registered colour outputs.
//
// Ports:
//   pclk            clock
//   reset           synchronous, active-high reset
//   x, y            horizontal / vertical counts (0..H_TOTAL-1, 0..V_TOTAL-1)
//   video_on        visible-area flag (undelayed)
//   horiz_sync_out  horizontal sync, level SYNC_POL when asserted, delayed
//   vert_sync_out   vertical sync, level SYNC_POL when asserted, delayed
//   pix_tick        one-pclk pulse on cycles where the counters advance
//   line_start      first pclk cycle of each line
//   frame_start     first pclk cycle of each frame
//
// Phase FSM states (both axes):
//   state   | meaning
//   PH_ACT  | visible region
//   PH_FP   | front porch
//   PH_SYNC | sync pulse
//   PH_BP   | back porch

module vga_timing_gen #(
    parameter int   CLK_DIV    = 2,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SYNC_DELAY = 1
) (
    input  logic       pclk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       horiz_sync_out,
    output logic       vert_sync_out,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1023) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL=%0d does not fit the 10-bit counter", H_TOTAL);
    end
    if (V_TOTAL > 1023) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL=%0d does not fit the 10-bit counter", V_TOTAL);
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV=%0d must be at least 1", CLK_DIV);
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_sync_delay
        $error("vga_timing_gen: SYNC_DELAY=%0d outside 0..4", SYNC_DELAY);
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    logic             running_q, running_d;
    logic             first_q, first_d;
    logic             line_wrap_q, line_wrap_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    phase_e           h_state_q, h_state_d;
    phase_e           v_state_q, v_state_d;
    logic             line_wrap;
    logic             hs_raw;
    logic             vs_raw;

    always_ff @(posedge pclk) begin
        if (reset) begin
            running_q   <= 1'b0;
            first_q     <= 1'b0;
            line_wrap_q <= 1'b0;
            div_cnt_q   <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            h_state_q   <= PH_ACT;
            v_state_q   <= PH_ACT;
        end else begin
            running_q   <= running_d;
            first_q     <= first_d;
            line_wrap_q <= line_wrap_d;
            div_cnt_q   <= div_cnt_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            h_state_q   <= h_state_d;
            v_state_q   <= v_state_d;
        end
    end

    // Divider and counters
    always_comb begin
        pix_tick  = running_q && (div_cnt_q == DIV_LAST);
        line_wrap = pix_tick && (h_cnt_q == H_LAST);

        running_d = 1'b1;
        // High only on the first running cycle (the edge that set running).
        first_d     = ~running_q;
        line_wrap_d = line_wrap;

        div_cnt_d = div_cnt_q;
        if (running_q) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        end

        h_cnt_d = h_cnt_q;
        if (pix_tick) begin
            h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
        end

        v_cnt_d = v_cnt_q;
        if (line_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Horizontal phase FSM
    always_comb begin
        h_state_d = h_state_q;
        if (pix_tick) begin
            case (h_state_q)
                PH_ACT:  if (h_cnt_q == H_ACT_END)  h_state_d = PH_FP;
                PH_FP:   if (h_cnt_q == H_FP_END)   h_state_d = PH_SYNC;
                PH_SYNC: if (h_cnt_q == H_SYNC_END) h_state_d = PH_BP;
                PH_BP:   if (h_cnt_q == H_LAST)     h_state_d = PH_ACT;
                default: h_state_d = PH_ACT;
            endcase
        end
    end

    // Vertical phase FSM, advancing only on the line-wrap tick
    always_comb begin
        v_state_d = v_state_q;
        if (line_wrap) begin
            case (v_state_q)
                PH_ACT:  if (v_cnt_q == V_ACT_END)  v_state_d = PH_FP;
                PH_FP:   if (v_cnt_q == V_FP_END)   v_state_d = PH_SYNC;
                PH_SYNC: if (v_cnt_q == V_SYNC_END) v_state_d = PH_BP;
                PH_BP:   if (v_cnt_q == V_LAST)     v_state_d = PH_ACT;
                default: v_state_d = PH_ACT;
            endcase
        end
    end

    always_comb begin
        x           = h_cnt_q;
        y           = v_cnt_q;
        video_on    = running_q && (h_cnt_q < H_ACT_LIM) && (v_cnt_q < V_ACT_LIM);
        line_start  = running_q && (h_cnt_q == 10'd0) && (line_wrap_q || first_q);
        frame_start = line_start && (v_cnt_q == 10'd0);
        hs_raw      = (h_state_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_raw      = (v_state_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    if (SYNC_DELAY == 0) begin : g_sync_comb
        assign horiz_sync_out = hs_raw;
        assign vert_sync_out  = vs_raw;
    end else begin : g_sync_dly
        logic [SYNC_DELAY-1:0] hs_sr_q, hs_sr_d;
        logic [SYNC_DELAY-1:0] vs_sr_q, vs_sr_d;

        // Shifts every pclk so the delay is in pclk cycles, not pixels.
        always_comb begin
            hs_sr_d    = hs_sr_q;
            vs_sr_d    = vs_sr_q;
            hs_sr_d[0] = hs_raw;
            vs_sr_d[0] = vs_raw;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                hs_sr_d[i] = hs_sr_q[i-1];
                vs_sr_d[i] = vs_sr_q[i-1];
            end
        end

        // Flushed to the inactive level so no stale pulse survives a reset.
        always_ff @(posedge pclk) begin
            if (reset) begin
                hs_sr_q <= {SYNC_DELAY{~SYNC_POL}};
                vs_sr_q <= {SYNC_DELAY{~SYNC_POL}};
            end else begin
                hs_sr_q <= hs_sr_d;
                vs_sr_q <= vs_sr_d;
            end
        end

        assign horiz_sync_out = hs_sr_q[SYNC_DELAY-1];
        assign vert_sync_out  = vs_sr_q[SYNC_DELAY-1];
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA game pipeline.
- Divides pclk into a pixel rate and runs the horizontal and vertical counters.
- Drives pixel coordinates (x, y) and video_on straight to the game/renderer stage.
- Drives horiz_sync/vert_sync, delayed to line up with the renderer's one-cycle registered colour outputs.
- Provides line_start/frame_start strobes so game logic can update once per frame instead of using free-running dividers.

Parameters:
- CLK_DIV, 2, pclk cycles per pixel (1 = pixel every pclk; 2 = 50 MHz board clock to 25 MHz pixel rate).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of both sync outputs (0 = active-low).
- SYNC_DELAY, 1, pclk cycles of delay on the sync outputs, range 0..4.

Ports:
- pclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- x  out  10  horizontal count h_cnt, 0..H_TOTAL-1
- y  out  10  vertical count v_cnt, 0..V_TOTAL-1
- video_on  out  1  high while h_cnt<H_ACTIVE and v_cnt<V_ACTIVE and running
- horiz_sync_out  out  1  horizontal sync, delayed by SYNC_DELAY
- vert_sync_out  out  1  vertical sync, delayed by SYNC_DELAY
- pix_tick  out  1  one-pclk pulse on the cycle the counters advance
- line_start  out  1  one-pclk pulse, first pclk cycle of h_cnt==0
- frame_start  out  1  one-pclk pulse, first pclk cycle of h_cnt==0 and v_cnt==0

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must fit in 10 bits; elaborate-time error otherwise.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0, running=0.
  - Both phase FSMs in ACT.
  - Sync shift registers filled with the inactive level ~SYNC_POL.
  - Outputs during reset: x=0, y=0, video_on=0, pix_tick=0, line_start=0, frame_start=0, both syncs = ~SYNC_POL.
- running is set on the first pclk edge with reset low and stays set.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while running.
  - pix_tick = running && div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick=1 on every running cycle.
- Horizontal counter, on pix_tick:
  - h_cnt = H_TOTAL-1 wraps to 0; otherwise increments.
- Vertical counter, on pix_tick with h_cnt==H_TOTAL-1:
  - v_cnt = V_TOTAL-1 wraps to 0; otherwise increments.
  - Line wrap and frame wrap occur on the same edge.
- Phase FSMs, one per axis, transitions on pix_tick only:
  - Horizontal: ACT -> FP at h_cnt==H_ACTIVE-1; FP -> SYNC at H_ACTIVE+H_FP-1; SYNC -> BP at H_ACTIVE+H_FP+H_SYNC-1; BP -> ACT at H_TOTAL-1.
  - Vertical: same structure using v_cnt and V_* limits, advancing only on the line-wrap tick.
  - FSM state must always agree with the decoded counter range; this is a bench assertion.
- Raw sync: hs_raw = SYNC_POL while the H FSM is in SYNC, else ~SYNC_POL; vs_raw likewise from the V FSM.
- Sync delay:
  - Each sync passes through a SYNC_DELAY-deep pclk shift register, clocked every pclk, not only on pix_tick.
  - SYNC_DELAY=0 makes the sync outputs combinational from the FSMs.
- x, y, video_on are undelayed, decoded directly from the counter registers. The downstream renderer registers colour, so that colour arrives aligned with the delayed syncs.
- line_start is high on each pclk cycle where running is set and h_cnt==0 and either:
  - the previous cycle's pix_tick wrapped the line, or
  - it is the first running cycle.
- frame_start follows the same rule, additionally requiring v_cnt==0.
- After reset release, the first running cycle shows video_on=1, x=0, y=0, line_start=1, frame_start=1.
- Reset asserted mid-frame: all state returns to reset values on the next edge; no partial line completes. The sync shift registers are flushed to the inactive level, so no residual sync pulse emerges after reset.

Test Plan:
- Reset held 5 cycles, then released, CLK_DIV=2 -> during reset video_on=0 and syncs=1. First cycle after release: frame_start=1, line_start=1, x=0, y=0, video_on=1. pix_tick first high on the 2nd cycle after release.
- Run one line, CLK_DIV=2 -> line_start period is 1600 pclk. video_on high for 1280 pclk. horiz_sync_out low for 192 pclk, starting 1 pclk after x becomes 656, ending 1 pclk after x becomes 752.
- Run two full frames -> frame_start period is 840000 pclk. vert_sync_out low while y is 490..491 (shifted 1 pclk). video_on=0 for all y>=480.
- Wrap check at x=799, y=524 followed by a pix_tick -> next values x=0, y=0, with line_start and frame_start both pulsing for exactly 1 pclk.
- Assert reset for 1 cycle at x=700 (inside hsync) -> the next cycle shows hsync inactive, x=0, y=0, video_on=0. Normal timing restarts with frame_start on the following cycle.
- Parameter variants:
  - CLK_DIV=1, SYNC_DELAY=0, SYNC_POL=1 -> pix_tick constant 1, line period 800 pclk, hsync high exactly while 656<=x<=751.
  - CLK_DIV=1, H_TOTAL=1024 -> elaboration error.
